// File: rtl/jericalla_pkg.sv
// jericalla_pkg: shared widths, instruction fields, halt encoding and fetch states
package jericalla_pkg;
   localparam int INSTR_W = 17;
   localparam int DEPTH = 16;
   localparam int PC_W = $clog2(DEPTH);
   localparam int EN_BIT = 16;
   localparam int DIR1_LO = 12;
   localparam int DIR2_LO = 8;
   localparam int OP_LO = 4;
   localparam int DIRW_LO = 0;
   localparam logic [INSTR_W-1:0] HALT_WORD = '0;
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
   // compare-only words (en=0) that leave zf set skip the following word
   function automatic logic [1:0] step_of(input logic [INSTR_W-1:0] w, input logic zf);
      return (!w[EN_BIT] && zf) ? 2'd2 : 2'd1;
   endfunction
endpackage

// File: rtl/jericalla_if.sv
// jericalla_if: instruction handshake between the fetch unit and the datapath
interface jericalla_if;
   import jericalla_pkg::*;
   logic [INSTR_W-1:0] instruction;
   logic instr_valid;
   logic instr_ready;
   logic zf_in;
   modport master (output instruction, output instr_valid, input instr_ready, input zf_in);
   modport slave (input instruction, input instr_valid, output instr_ready, output zf_in);
endinterface

// File: rtl/jericalla_imem.sv
// jericalla_imem: program memory with one write port and one registered read port
module jericalla_imem
   import jericalla_pkg::*;
(
   input  logic clk,
   input  logic we,
   input  logic [PC_W-1:0] waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [PC_W-1:0] raddr,
   output logic [INSTR_W-1:0] rdata
);
   logic [INSTR_W-1:0] mem [DEPTH];
   // write-first so a word loaded in the start cycle is what gets fetched
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
   end
endmodule

// File: rtl/jericalla_fetch.sv
// jericalla_fetch: program sequencer issuing instructions to the Jericalla datapath
module jericalla_fetch
   import jericalla_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic prog_we,
   input  logic [PC_W-1:0] prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   jericalla_if.master bus,
   output logic [PC_W-1:0] pc,
   output logic busy,
   output logic done
);
   state_t state;
   logic [INSTR_W-1:0] word;
   logic [PC_W:0] sum;
   logic [PC_W-1:0] raddr;
   logic go, adv;
   assign go = start && (state == IDLE || state == DONE);
   assign sum = {1'b0, pc} + {{(PC_W-1){1'b0}}, step_of(bus.instruction, bus.zf_in)};
   assign adv = state == ISSUE && bus.instr_ready && !sum[PC_W];
   // read is launched with the pc being loaded, so the word is ready in FETCH
   assign raddr = go ? '0 : adv ? sum[PC_W-1:0] : pc;
   jericalla_imem u_imem (
      .clk(clk),
      .we(prog_we && !busy),
      .waddr(prog_addr),
      .wdata(prog_data),
      .raddr(raddr),
      .rdata(word)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc <= '0;
         bus.instruction <= '0;
         bus.instr_valid <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state <= FETCH;
               pc <= '0;
               busy <= 1'b1;
               done <= 1'b0;
            end
            FETCH: if (word == HALT_WORD) begin
               state <= DONE;
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               state <= ISSUE;
               bus.instruction <= word;
               bus.instr_valid <= 1'b1;
            end
            ISSUE: if (bus.instr_ready) begin
               bus.instr_valid <= 1'b0;
               state <= adv ? FETCH : DONE;
               pc <= adv ? sum[PC_W-1:0] : pc;
               busy <= adv;
               done <= !adv;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_jericalla_fetch.sv
// tb_jericalla_fetch: scoreboard bench for the Jericalla instruction sequencer
module tb_jericalla_fetch;
   import jericalla_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic prog_we = 1'b0;
   logic [PC_W-1:0] prog_addr = '0;
   logic [INSTR_W-1:0] prog_data = '0;
   logic [PC_W-1:0] pc;
   logic busy, done;
   logic [INSTR_W-1:0] m [DEPTH];
   logic [INSTR_W-1:0] q [$];
   int n_chk = 0;
   int n_fail = 0;
   int exp_pc = 0;
   jericalla_if bus();
   jericalla_fetch dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .prog_we(prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data),
      .bus(bus),
      .pc(pc),
      .busy(busy),
      .done(done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic load(input int a, input logic [INSTR_W-1:0] d);
      prog_we = 1'b1;
      prog_addr = a[PC_W-1:0];
      prog_data = d;
      m[a] = d;
      tick;
      prog_we = 1'b0;
   endtask
   // expected issue order of the program in m with zf held constant
   task automatic plan(input logic zf);
      int p;
      int s;
      p = 0;
      bus.zf_in = zf;
      for (int k = 0; k < DEPTH; k++) begin
         if (m[p] == HALT_WORD) break;
         q.push_back(m[p]);
         s = (!m[p][16] && zf) ? 2 : 1;
         if (p + s > DEPTH - 1) break;
         p += s;
      end
      exp_pc = p;
   endtask
   task automatic kick;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask
   task automatic finish_run(input int budget);
      for (int i = 0; i < budget && !done; i++) tick;
      check("done", done, 1);
      check("busy", busy, 0);
      check("end_pc", pc, exp_pc);
      check("sb_empty", q.size(), 0);
   endtask
   always @(negedge clk) begin
      if (rst_n && bus.instr_valid && bus.instr_ready) begin
         check("sb_pending", q.size() != 0, 1);
         if (q.size() != 0) check("issue", bus.instruction, q.pop_front());
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.instr_ready = 1'b1;
      bus.zf_in = 1'b0;
      #12;
      check("rst_pc", pc, 0);
      check("rst_valid", bus.instr_valid, 0);
      check("rst_instr", bus.instruction, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      tick;
      load(0, 17'h14601);
      load(1, 17'h0);
      plan(1'b0);
      kick;
      check("t1_lat1_valid", bus.instr_valid, 0);
      tick;
      check("t1_lat2_valid", bus.instr_valid, 1);
      check("t1_lat2_instr", bus.instruction, 17'h14601);
      tick;
      check("t1_drop_valid", bus.instr_valid, 0);
      finish_run(10);
      bus.instr_ready = 1'b0;
      load(0, 17'h14612);
      plan(1'b0);
      kick;
      tick;
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", bus.instr_valid, 1);
         check("t2_hold_instr", bus.instruction, 17'h14612);
         check("t2_hold_pc", pc, 0);
         tick;
      end
      bus.instr_ready = 1'b1;
      tick;
      check("t2_pc_adv", pc, 1);
      check("t2_valid_drop", bus.instr_valid, 0);
      finish_run(10);
      load(0, 17'h046F0);
      load(1, 17'h11111);
      load(2, 17'h12222);
      load(3, 17'h0);
      plan(1'b1);
      kick;
      finish_run(20);
      plan(1'b0);
      kick;
      finish_run(20);
      for (int i = 0; i < DEPTH; i++) load(i, 17'h10000 | 17'(i * 17'h111));
      plan(1'b0);
      kick;
      finish_run(60);
      repeat (3) tick;
      check("t4_no_wrap", pc, DEPTH - 1);
      check("t4_idle_valid", bus.instr_valid, 0);
      bus.instr_ready = 1'b0;
      plan(1'b0);
      kick;
      tick;
      check("t5_pre_valid", bus.instr_valid, 1);
      rst_n = 1'b0;
      #1;
      check("t5_async_valid", bus.instr_valid, 0);
      check("t5_async_pc", pc, 0);
      check("t5_async_busy", busy, 0);
      check("t5_async_done", done, 0);
      q.delete();
      tick;
      rst_n = 1'b1;
      bus.instr_ready = 1'b1;
      plan(1'b0);
      kick;
      finish_run(60);
      bus.instr_ready = 1'b0;
      plan(1'b0);
      kick;
      tick;
      prog_we = 1'b1;
      prog_addr = '0;
      prog_data = 17'h1ABCD;
      start = 1'b1;
      tick;
      prog_we = 1'b0;
      start = 1'b0;
      check("t6_busy", busy, 1);
      check("t6_pc", pc, 0);
      check("t6_valid", bus.instr_valid, 1);
      check("t6_instr", bus.instruction, m[0]);
      bus.instr_ready = 1'b1;
      finish_run(60);
      plan(1'b0);
      kick;
      finish_run(60);
      m[0] = 17'h15555;
      plan(1'b0);
      prog_we = 1'b1;
      prog_addr = '0;
      prog_data = 17'h15555;
      start = 1'b1;
      tick;
      prog_we = 1'b0;
      start = 1'b0;
      tick;
      check("t7_first_instr", bus.instruction, 17'h15555);
      finish_run(60);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
